// File: rtl/rv32i_pkg.sv
// RV32I decode definitions: base opcodes, instruction format enum, decoded field bundle.
// No logic; shared by the decode stage and its immediate generator.
package rv32i_pkg;

    localparam logic [6:0] LUI      = 7'h37;
    localparam logic [6:0] AUIPC    = 7'h17;
    localparam logic [6:0] JAL      = 7'h6F;
    localparam logic [6:0] JALR     = 7'h67;
    localparam logic [6:0] BRANCH   = 7'h63;
    localparam logic [6:0] LOAD     = 7'h03;
    localparam logic [6:0] STORE    = 7'h23;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP       = 7'h33;
    localparam logic [6:0] MISC_MEM = 7'h0F;
    localparam logic [6:0] SYSTEM   = 7'h73;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    // XLEN-independent part of a decoded entry; pc and imm are added per instance.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
        fmt_e       fmt;
        logic       illegal;
    } fields_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extended XLEN immediate chosen by instruction format.
// Purely combinational; no state and no handshake.
module imm_gen
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst_i,
    input  fmt_e            fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = 32'd0;
        case (fmt_i)
            FMT_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            FMT_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            FMT_B:   imm32 = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            FMT_U:   imm32 = {inst_i[31:12], 12'd0};
            FMT_J:   imm32 = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    // Every 32-bit immediate already carries inst[31] as its sign; widen it to XLEN.
    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: fields, format, immediate and illegal flag; 1-cycle latency.
// Backpressure through a 2-entry skid (registered in_ready_o) or a single register when SKID_EN=0.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SKID_EN    = 1,
    parameter int ILLEGAL_EN = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [6:0]      opcode_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [6:0]      funct7_o,
    output logic [2:0]      fmt_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        fields_t         f;
        logic [XLEN-1:0] imm;
    } decoded_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    fmt_e       fmt_dec;
    logic       ill_raw;
    fields_t    f_dec;
    logic [XLEN-1:0] imm_dec;
    decoded_t   in_ent;

    assign opc = inst_i[6:0];
    assign f3  = inst_i[14:12];
    assign f7  = inst_i[31:25];

    always_comb begin
        fmt_dec = FMT_NONE;
        ill_raw = 1'b0;
        case (opc)
            OP: begin
                fmt_dec = FMT_R;
                if (f7 != FUNCT7_BASE && f7 != FUNCT7_ALT) ill_raw = 1'b1;
                if (f7 == FUNCT7_ALT && f3 != 3'd0 && f3 != 3'd5) ill_raw = 1'b1;
            end
            OP_IMM: begin
                fmt_dec = FMT_I;
                // Only the shift encodings constrain funct7.
                if (f3 == 3'd1 && f7 != FUNCT7_BASE) ill_raw = 1'b1;
                if (f3 == 3'd5 && f7 != FUNCT7_BASE && f7 != FUNCT7_ALT) ill_raw = 1'b1;
            end
            LOAD: begin
                fmt_dec = FMT_I;
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ill_raw = 1'b1;
            end
            JALR: begin
                fmt_dec = FMT_I;
                if (f3 != 3'd0) ill_raw = 1'b1;
            end
            SYSTEM, MISC_MEM: fmt_dec = FMT_I;
            STORE: begin
                fmt_dec = FMT_S;
                if (f3 > 3'd2) ill_raw = 1'b1;
            end
            BRANCH: begin
                fmt_dec = FMT_B;
                if (f3 == 3'd2 || f3 == 3'd3) ill_raw = 1'b1;
            end
            LUI, AUIPC: fmt_dec = FMT_U;
            JAL:        fmt_dec = FMT_J;
            default: begin
                fmt_dec = FMT_NONE;
                ill_raw = 1'b1;
            end
        endcase
        if (inst_i[1:0] != 2'b11) ill_raw = 1'b1;
    end

    always_comb begin
        f_dec.opcode  = opc;
        f_dec.rd      = (fmt_dec == FMT_S || fmt_dec == FMT_B) ? 5'd0 : inst_i[11:7];
        f_dec.funct3  = f3;
        f_dec.rs1     = (fmt_dec == FMT_U || fmt_dec == FMT_J) ? 5'd0 : inst_i[19:15];
        f_dec.rs2     = (fmt_dec == FMT_R || fmt_dec == FMT_S || fmt_dec == FMT_B)
                        ? inst_i[24:20] : 5'd0;
        f_dec.funct7  = f7;
        f_dec.fmt     = fmt_dec;
        f_dec.illegal = (ILLEGAL_EN != 0) && ill_raw;
    end

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .inst_i (inst_i[31:7]),
        .fmt_i  (fmt_dec),
        .imm_o  (imm_dec)
    );

    assign in_ent = '{pc: pc_i, f: f_dec, imm: imm_dec};

    logic [1:0] state_q, state_d;
    logic       in_rdy_q;
    decoded_t   main_q, main_d;
    decoded_t   skid_q, skid_d;
    logic       in_fire, out_fire;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign in_ready_o  = (SKID_EN != 0) ? in_rdy_q : (!out_valid_o || out_ready_i);
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_o && out_ready_i;

    // With SKID_EN=0, ONE only accepts while draining, so TWO is unreachable.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_ent;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && !out_fire) begin
                    skid_d  = in_ent;
                    state_d = ST_TWO;
                end else if (in_fire && out_fire) begin
                    main_d  = in_ent;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush_i) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_EMPTY;
            in_rdy_q <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state_q  <= state_d;
            in_rdy_q <= (state_d != ST_TWO);
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

    assign pc_o      = main_q.pc;
    assign opcode_o  = main_q.f.opcode;
    assign rd_o      = main_q.f.rd;
    assign funct3_o  = main_q.f.funct3;
    assign rs1_o     = main_q.f.rs1;
    assign rs2_o     = main_q.f.rs2;
    assign funct7_o  = main_q.f.funct7;
    assign fmt_o     = main_q.f.fmt;
    assign imm_o     = main_q.imm;
    assign illegal_o = main_q.f.illegal;

endmodule
